mem_ctrl: RTL and testbench

- Arbiter and sequencer for the single 8-bit synchronous RAM port.
- Shared between instruction fetch (IF) and the load/store stage (MEM).
- Serialises 1/2/4-byte accesses into byte cycles, assembles little-endian read data, and returns a one-cycle ack to the granted requester.
- The pipeline controller stalls on "request high and no ack".

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the single-port byte RAM sequencer.
// State encodings, access size codes and the size-to-last-byte helper.
package mem_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READ      = 3'd1;
  localparam logic [2:0] ST_READ_LAST = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Index of the final byte; size 11 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      SIZE_BYTE: r = 2'd0;
      SIZE_HALF: r = 2'd1;
      default:   r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// IF/MEM arbiter and byte-serial sequencer for an 8-bit synchronous RAM.
// Optional MEM_CTRL_IF_ABORT_EN adds if_abort_i to cancel an in-flight fetch.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
`ifdef MEM_CTRL_IF_ABORT_EN
  input  logic                  if_abort_i,
`endif
  output logic                  if_ack_o,
  output logic [31:0]           if_data_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_ack_o,
  output logic [31:0]           mem_rdata_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  logic [2:0]            state;
  logic                  grant_mem;
  logic                  we;
  logic [RAM_ADDR_W-1:0] base;
  logic [1:0]            last;
  logic [1:0]            idx;
  logic [1:0]            prev;
  logic [31:0]           wdata;
  logic [31:0]           asm_data;
  logic [RAM_ADDR_W-1:0] addr;
  logic                  abort_now;
  logic                  abort_hit;
  logic                  is_ack;
  logic                  unused_addr;

`ifdef MEM_CTRL_IF_ABORT_EN
  assign abort_now = if_abort_i;
`else
  assign abort_now = 1'b0;
`endif

  assign abort_hit   = abort_now && !grant_mem;
  assign prev        = idx - 2'd1;
  assign addr        = base + {{(RAM_ADDR_W-2){1'b0}}, idx};
  assign unused_addr = ^{if_addr_i[31:RAM_ADDR_W], mem_addr_i[31:RAM_ADDR_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      grant_mem <= 1'b0;
      we        <= 1'b0;
      base      <= '0;
      last      <= 2'd0;
      idx       <= 2'd0;
      wdata     <= '0;
      asm_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_req_i || if_req_i) begin
            grant_mem <= mem_req_i;
            idx       <= 2'd0;
            asm_data  <= '0;
            if (mem_req_i) begin
              we    <= mem_we_i;
              base  <= mem_addr_i[RAM_ADDR_W-1:0];
              last  <= last_idx(mem_size_i);
              wdata <= mem_wdata_i;
              state <= mem_we_i ? ST_WRITE : ST_READ;
            end else begin
              we    <= 1'b0;
              base  <= if_addr_i[RAM_ADDR_W-1:0];
              last  <= 2'd3;
              wdata <= '0;
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (abort_hit) begin
            asm_data <= '0;
            state    <= ST_IDLE;
          end else begin
            // RAM data lags the address by one cycle.
            if (idx != 2'd0)
              asm_data[{prev, 3'b000} +: 8] <= ram_din_i;
            if (idx == last)
              state <= ST_READ_LAST;
            else
              idx <= idx + 2'd1;
          end
        end
        ST_READ_LAST: begin
          if (abort_hit) begin
            asm_data <= '0;
            state    <= ST_IDLE;
          end else begin
            asm_data[{last, 3'b000} +: 8] <= ram_din_i;
            state <= ST_ACK;
          end
        end
        ST_WRITE: begin
          if (idx == last)
            state <= ST_ACK;
          else
            idx <= idx + 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign is_ack      = (state == ST_ACK);
  assign if_ack_o    = is_ack && !grant_mem && !abort_now;
  assign mem_ack_o   = is_ack && grant_mem;
  assign if_data_o   = if_ack_o ? asm_data : 32'd0;
  assign mem_rdata_o = mem_ack_o ? asm_data : 32'd0;

  assign ram_wr_o   = (state == ST_WRITE);
  assign ram_addr_o = (state == ST_READ || state == ST_WRITE) ? addr : '0;
  assign ram_dout_o = ram_wr_o ? wdata[{idx, 3'b000} +: 8] : 8'd0;

  // Keeps the write-side register live even when only reads occur.
  logic unused_we;
  assign unused_we = we;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table, scoreboard, corner sequences.
// Define MEM_CTRL_IF_ABORT_EN to also exercise the fetch abort path.
module tb_mem_ctrl;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_ack;
  logic [31:0]   if_data;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [1:0]    mem_size = '0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din = '0;
`ifdef MEM_CTRL_IF_ABORT_EN
  logic          if_abort = 1'b0;
`endif

  mem_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
`ifdef MEM_CTRL_IF_ABORT_EN
    .if_abort_i (if_abort),
`endif
    .if_ack_o   (if_ack),
    .if_data_o  (if_data),
    .mem_req_i  (mem_req),
    .mem_we_i   (mem_we),
    .mem_size_i (mem_size),
    .mem_addr_i (mem_addr),
    .mem_wdata_i(mem_wdata),
    .mem_ack_o  (mem_ack),
    .mem_rdata_o(mem_rdata),
    .ram_addr_o (ram_addr),
    .ram_wr_o   (ram_wr),
    .ram_dout_o (ram_dout),
    .ram_din_i  (ram_din)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t           wr_log[$];
  logic [AW-1:0] addr_log[$];
  bit            log_addr = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Ack monitor and scoreboard pop.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_wr) wr_log.push_back('{ram_addr, ram_dout});
      if (log_addr && ram_addr != '0) addr_log.push_back(ram_addr);
      if (if_ack && mem_ack) check("ack_exclusive", 2'b11, 2'b01);
      if (if_ack || mem_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {if_ack, mem_ack}, 2'b00);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_source", {if_ack, mem_ack}, {!e.is_mem, e.is_mem});
          check("ack_data", mem_ack ? mem_rdata : if_data, e.data);
          check("ack_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic wait_ack(input bit is_mem, input string name);
    bit done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (is_mem ? mem_ack : if_ack) done = 1'b1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s: got no ack expected ack within 20 cycles", name);
    end
  endtask

  task automatic do_mem(input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input int lat);
    @(posedge clk);
    #1;
    mem_req   = 1'b1;
    mem_we    = we;
    mem_size  = size;
    mem_addr  = addr;
    mem_wdata = wdata;
    sb.push_back('{1'b1, exp, cyc + lat});
    wait_ack(1'b1, "mem_timeout");
    mem_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp);
    @(posedge clk);
    #1;
    if_req  = 1'b1;
    if_addr = addr;
    sb.push_back('{1'b0, exp, cyc + 6});
    wait_ack(1'b0, "if_timeout");
    if_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vec[10];

  initial begin
    int n;
    int s;
    vec[0] = '{1'b0, 2'b01, 32'h0000_0301, 32'h0, 32'h0000_BBAA, 4};
    vec[1] = '{1'b0, 2'b11, 32'h0000_0400, 32'h0, 32'h0403_0201, 6};
    vec[2] = '{1'b0, 2'b00, 32'h0000_0402, 32'h0, 32'h0000_0003, 3};
    vec[3] = '{1'b1, 2'b10, 32'h0001_FFFF, 32'hDEAD_BEEF, 32'h0, 5};
    vec[4] = '{1'b1, 2'b01, 32'h0000_0500, 32'hCAFE_1234, 32'h0, 3};
    vec[5] = '{1'b0, 2'b10, 32'h0001_FFFF, 32'h0, 32'hDEAD_BEEF, 6};
    vec[6] = '{1'b0, 2'b01, 32'h0000_0500, 32'h0, 32'h0000_1234, 4};
    vec[7] = '{1'b1, 2'b00, 32'h0000_0600, 32'hFFFF_FF5A, 32'h0, 2};
    vec[8] = '{1'b0, 2'b00, 32'h0000_0600, 32'h0, 32'h0000_005A, 3};
    vec[9] = '{1'b0, 2'b10, 32'h0002_0301, 32'h0, 32'hDDCC_BBAA, 6};

    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    ram['h100] = 8'h11; ram['h101] = 8'h22;
    ram['h102] = 8'h33; ram['h103] = 8'h44;
    ram['h301] = 8'hAA; ram['h302] = 8'hBB;
    ram['h303] = 8'hCC; ram['h304] = 8'hDD;
    ram['h400] = 8'h01; ram['h401] = 8'h02;
    ram['h402] = 8'h03; ram['h403] = 8'h04;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {if_ack, mem_ack, ram_wr, ram_addr, ram_dout, if_data, mem_rdata},
          '0);
    @(negedge clk);
    rst = 1'b1;

    // Word fetch with address trace.
    addr_log.delete();
    log_addr = 1'b1;
    do_fetch(32'h0000_0100, 32'h4433_2211);
    log_addr = 1'b0;
    check("fetch_addr_count", addr_log.size(), 4);
    for (int k = 0; k < addr_log.size() && k < 4; k++)
      check("fetch_addr_seq", addr_log[k], AW'('h100 + k));

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      wr_log.delete();
      do_mem(vec[i].we, vec[i].size, vec[i].addr, vec[i].wdata,
             vec[i].exp, vec[i].lat);
      n = (vec[i].size == 2'b00) ? 1 : (vec[i].size == 2'b01) ? 2 : 4;
      check("write_count", wr_log.size(), vec[i].we ? n : 0);
      if (vec[i].we) begin
        for (int k = 0; k < wr_log.size() && k < n; k++) begin
          logic [AW-1:0] ea;
          logic [31:0]   wd;
          ea = AW'(vec[i].addr + 32'(k));
          wd = vec[i].wdata >> (8 * k);
          check("write_addr", wr_log[k].a, ea);
          check("write_byte", wr_log[k].d, wd[7:0]);
        end
      end
    end

    // Simultaneous requests: MEM store wins, fetch follows.
    wr_log.delete();
    @(posedge clk);
    #1;
    s = cyc;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0100;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_size  = 2'b00;
    mem_addr  = 32'h0000_0200;
    mem_wdata = 32'h0000_00AB;
    sb.push_back('{1'b1, 32'h0, s + 2});
    sb.push_back('{1'b0, 32'h4433_2211, s + 9});
    wait_ack(1'b1, "simul_mem_timeout");
    mem_req = 1'b0;
    wait_ack(1'b0, "simul_if_timeout");
    if_req = 1'b0;
    check("simul_write_count", wr_log.size(), 1);
    check("simul_ram", ram['h200], 8'hAB);

    // Reset during the second write cycle of a word store.
    @(posedge clk);
    #1;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_size  = 2'b10;
    mem_addr  = 32'h0000_0700;
    mem_wdata = 32'h4433_2211;
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_wr", {ram_wr, ram_addr, ram_dout}, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_idle_outputs", {ram_wr, ram_addr, if_ack, mem_ack}, '0);
    check("rst_byte0", ram['h700], 8'h11);
    check("rst_byte1", ram['h701], 8'h00);
    do_mem(1'b0, 2'b10, 32'h0000_0700, 32'h0, 32'h0000_0011, 6);

`ifdef MEM_CTRL_IF_ABORT_EN
    // Abort a fetch in its third cycle; pending load is granted next.
    @(posedge clk);
    #1;
    s = cyc;
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    @(posedge clk);
    #1;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_size = 2'b00;
    mem_addr = 32'h0000_0402;
    sb.push_back('{1'b1, 32'h0000_0003, s + 7});
    repeat (2) @(posedge clk);
    #1;
    if_abort = 1'b1;
    if_req   = 1'b0;
    @(posedge clk);
    #1;
    if_abort = 1'b0;
    wait_ack(1'b1, "abort_mem_timeout");
    mem_req = 1'b0;
    repeat (3) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
